// File: rtl/seg7_hex_scan_if.sv
// Bus between the value producer and the 8-digit 7-segment scanner.
//
// Handshake: load is a single-cycle strobe with no back-pressure. The scanner
// always accepts it; value/dp_in only need to be valid in the cycle where
// load is high. The display side (an/seg/dp/frame_start) is free-running.
interface seg7_hex_scan_if;
  logic        load;
  logic [31:0] value;
  logic [7:0]  dp_in;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;
  // Scan-state observation: current digit index and gap-phase flag.
  logic [2:0]  dbg_idx;
  logic        dbg_gap;

  modport master (
    output load, value, dp_in, blank_lz,
    input  an, seg, dp, frame_start, dbg_idx, dbg_gap
  );

  modport slave (
    input  load, value, dp_in, blank_lz,
    output an, seg, dp, frame_start, dbg_idx, dbg_gap
  );
endinterface

// File: rtl/seg7_hex_scan.sv
// 8-digit common-anode 7-segment scanner for a 32-bit hex value.
// One digit per slot of SCAN_DIV cycles; the first GAP_CYC cycles of every
// slot turn all anodes off to suppress ghosting. New values are staged in a
// pending buffer and only become active on the frame wrap (digit 7 -> 0) so a
// frame is never drawn from two different values.
module seg7_hex_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int GAP_CYC  = 50
) (
  input  logic           clk,
  input  logic           rst,
  seg7_hex_scan_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_CYC);

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [31:0]      r_pend_val;
  logic [7:0]       r_pend_dp;
  logic             r_pend_valid;
  logic [31:0]      r_active_val;
  logic [7:0]       r_active_dp;
  logic [7:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_frame_start;

  logic             w_slot_end;
  logic             w_wrap;
  logic             w_gap;
  logic [7:0]       w_lz;
  logic [7:0]       w_blank;
  logic [3:0]       w_nib;

  // Hex digit to active-low {g..a} segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_wrap     = w_slot_end && (r_idx == 3'd7);
  assign w_gap      = (r_cnt < CNT_GAP);
  assign w_nib      = r_active_val[{r_idx, 2'b00} +: 4];

  // w_lz[i] is set when nibbles i..7 of the active value are all zero.
  always_comb begin
    w_lz    = '0;
    w_lz[7] = (r_active_val[31:28] == 4'h0);
    for (int i = 6; i >= 0; i--) begin
      w_lz[i] = w_lz[i+1] && (r_active_val[4*i +: 4] == 4'h0);
    end
  end

  // Digit 0 is never blanked so a zero value still shows a single "0".
  assign w_blank = bus.blank_lz ? {w_lz[7:1], 1'b0} : 8'h00;

  // Slot counter and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Pending/active double buffer; a load on the wrap cycle stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_active_val <= '0;
      r_active_dp  <= '0;
    end else begin
      if (w_wrap && r_pend_valid) begin
        r_active_val <= r_pend_val;
        r_active_dp  <= r_pend_dp;
      end
      if (bus.load) begin
        r_pend_val   <= bus.value;
        r_pend_dp    <= bus.dp_in;
        r_pend_valid <= 1'b1;
      end else if (w_wrap) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // Registered display drive from the current slot state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an          <= 8'hFF;
      r_seg         <= 7'h7F;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_wrap;
      if (w_gap) begin
        r_an  <= 8'hFF;
        r_seg <= 7'h7F;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= ~(8'h01 << r_idx);
        r_seg <= w_blank[r_idx] ? 7'h7F : hex_to_seg(w_nib);
        r_dp  <= ~r_active_dp[r_idx];
      end
    end
  end

  assign bus.an          = r_an;
  assign bus.seg         = r_seg;
  assign bus.dp          = r_dp;
  assign bus.frame_start = r_frame_start;
  assign bus.dbg_idx     = r_idx;
  assign bus.dbg_gap     = w_gap;

endmodule

// File: tb/tb_seg7_hex_scan.sv
// Directed bench for seg7_hex_scan with SCAN_DIV=8, GAP_CYC=2.
// Time reference: e_cnt counts rising edges since reset release. After edge E
// the outputs reflect slot state index E-1: digit ((E-1)/8)%8, slot cycle
// (E-1)%8, and frame (E-1)/64. A load sampled on edge 64*f is the wrap-cycle
// load; loads before it become active for frame f.
module tb_seg7_hex_scan;

  logic clk;
  logic rst;
  int   e_cnt;
  int   n_assert;
  int   n_fail;

  seg7_hex_scan_if bus_if ();

  seg7_hex_scan #(
    .SCAN_DIV (8),
    .GAP_CYC  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  // Clock and edge reference
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) e_cnt <= 0;
    else     e_cnt <= e_cnt + 1;
  end

  // Advance to the falling edge after rising edge e (bounded).
  task automatic goto_edge(input int e);
    int guard;
    guard = 0;
    while (e_cnt < e && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (e_cnt < e) begin
      n_assert++;
      n_fail++;
      $error("FAIL timeout waiting for edge %0d: observed %0d", e, e_cnt);
    end
  endtask

  // Present a load so it is sampled on rising edge e.
  task automatic do_load(input int e, input logic [31:0] v, input logic [7:0] d);
    goto_edge(e - 1);
    bus_if.load  = 1'b1;
    bus_if.value = v;
    bus_if.dp_in = d;
    @(negedge clk);
    bus_if.load  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] e_an,
                     input logic [6:0] e_seg, input logic e_dp);
    n_assert++;
    assert (bus_if.an === e_an) else begin
      n_fail++;
      $error("FAIL %s an: observed %h expected %h", tag, bus_if.an, e_an);
    end
    n_assert++;
    assert (bus_if.seg === e_seg) else begin
      n_fail++;
      $error("FAIL %s seg: observed %h expected %h", tag, bus_if.seg, e_seg);
    end
    n_assert++;
    assert (bus_if.dp === e_dp) else begin
      n_fail++;
      $error("FAIL %s dp: observed %b expected %b", tag, bus_if.dp, e_dp);
    end
  endtask

  task automatic chk_fs(input string tag, input logic e_fs);
    n_assert++;
    assert (bus_if.frame_start === e_fs) else begin
      n_fail++;
      $error("FAIL %s frame_start: observed %b expected %b", tag, bus_if.frame_start, e_fs);
    end
  endtask

  initial begin
    n_assert        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    bus_if.load     = 1'b0;
    bus_if.value    = '0;
    bus_if.dp_in    = '0;
    bus_if.blank_lz = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset", 8'hFF, 7'h7F, 1'b1);
    chk_fs("reset", 1'b0);
    n_assert++;
    assert (bus_if.dbg_idx === 3'd0) else begin
      n_fail++;
      $error("FAIL reset dbg_idx: observed %0d expected 0", bus_if.dbg_idx);
    end
    rst = 1'b0;

    // 1: blank scan of zeros, frame 0
    goto_edge(1);  chk("f0 d0 gap0", 8'hFF, 7'h7F, 1'b1);
    goto_edge(2);  chk("f0 d0 gap1", 8'hFF, 7'h7F, 1'b1);
    goto_edge(3);  chk("f0 d0 on",   8'hFE, 7'h40, 1'b1);
    goto_edge(8);  chk("f0 d0 last", 8'hFE, 7'h40, 1'b1);
    goto_edge(9);  chk("f0 d1 gap",  8'hFF, 7'h7F, 1'b1);
    n_assert++;
    assert (bus_if.dbg_idx === 3'd1) else begin
      n_fail++;
      $error("FAIL f0 dbg_idx: observed %0d expected 1", bus_if.dbg_idx);
    end
    goto_edge(11); chk("f0 d1 on",   8'hFD, 7'h40, 1'b1);

    // 2: full hex, loaded mid frame 0, shown in frame 1
    do_load(30, 32'h89ABCDEF, 8'h00);
    goto_edge(35); chk("f0 d4 unchanged", 8'hEF, 7'h40, 1'b1);
    goto_edge(59); chk("f0 d7 on", 8'h7F, 7'h40, 1'b1);
    goto_edge(63); chk_fs("before wrap", 1'b0);
    goto_edge(64); chk_fs("wrap 1", 1'b1);
    goto_edge(65); chk_fs("after wrap", 1'b0);
    chk("f1 d0 gap", 8'hFF, 7'h7F, 1'b1);
    goto_edge(67); chk("f1 d0 F", 8'hFE, 7'h0E, 1'b1);
    goto_edge(75); chk("f1 d1 E", 8'hFD, 7'h06, 1'b1);
    goto_edge(91); chk("f1 d3 C", 8'hF7, 7'h46, 1'b1);

    // 3: leading-zero blanking, loaded in frame 1, shown in frame 2
    bus_if.blank_lz = 1'b1;
    do_load(100, 32'h000000A0, 8'h00);
    goto_edge(123); chk("f1 d7 8", 8'h7F, 7'h00, 1'b1);
    goto_edge(128); chk("f1 d7 last", 8'h7F, 7'h00, 1'b1);
    chk_fs("wrap 2", 1'b1);
    goto_edge(131); chk("f2 d0 0",     8'hFE, 7'h40, 1'b1);
    goto_edge(139); chk("f2 d1 A",     8'hFD, 7'h08, 1'b1);
    goto_edge(147); chk("f2 d2 blank", 8'hFB, 7'h7F, 1'b1);

    // 5: zero value with dp on digits 0 and 2, shown in frame 3
    do_load(170, 32'h00000000, 8'h05);
    goto_edge(187); chk("f2 d7 blank", 8'h7F, 7'h7F, 1'b1);
    goto_edge(195); chk("f3 d0 0 dp",  8'hFE, 7'h40, 1'b0);
    goto_edge(203); chk("f3 d1 blank", 8'hFD, 7'h7F, 1'b1);
    goto_edge(209); chk("f3 d2 gap",   8'hFF, 7'h7F, 1'b1);
    goto_edge(211); chk("f3 d2 blank dp", 8'hFB, 7'h7F, 1'b0);
    goto_edge(219); chk("f3 d3 blank", 8'hF7, 7'h7F, 1'b1);

    // 4: tearing guard; mid-frame load, then a load on the wrap edge
    do_load(230, 32'h11111111, 8'h00);
    goto_edge(235); chk("f3 d5 unchanged", 8'hDF, 7'h7F, 1'b1);
    do_load(256, 32'h22222222, 8'h00);
    goto_edge(259); chk("f4 d0 1", 8'hFE, 7'h79, 1'b1);
    goto_edge(315); chk("f4 d7 1", 8'h7F, 7'h79, 1'b1);
    goto_edge(320); chk_fs("wrap 5", 1'b1);
    goto_edge(323); chk("f5 d0 2", 8'hFE, 7'h24, 1'b1);
    goto_edge(331); chk("f5 d1 2", 8'hFD, 7'h24, 1'b1);

    // 6: async reset mid-slot on digit 3, pending load discarded
    do_load(340, 32'h33333333, 8'hFF);
    goto_edge(348); chk("f5 d3 2", 8'hF7, 7'h24, 1'b1);
    #2 rst = 1'b1;
    #1 chk("async reset", 8'hFF, 7'h7F, 1'b1);
    chk_fs("async reset", 1'b0);
    bus_if.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset held", 8'hFF, 7'h7F, 1'b1);
    rst = 1'b0;
    goto_edge(1);  chk("rr d0 gap", 8'hFF, 7'h7F, 1'b1);
    goto_edge(3);  chk("rr d0 0",   8'hFE, 7'h40, 1'b1);
    goto_edge(11); chk("rr d1 0",   8'hFD, 7'h40, 1'b1);
    goto_edge(64); chk_fs("rr wrap", 1'b1);
    goto_edge(67); chk("rr f1 d0 0", 8'hFE, 7'h40, 1'b1);
    goto_edge(75); chk("rr f1 d1 0", 8'hFD, 7'h40, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_hex_scan.md
Name: seg7_hex_scan

Overview:
- Drives the calculator's 8-digit common-anode 7-segment display from a 32-bit hex value. This is the output end of the user interface; the debounced key inputs are the input end.
- Time-multiplexes one digit at a time, with an anode-off gap between digits to suppress ghosting.
- Optionally blanks leading zeros.
- Double-buffers the displayed value so a new value only takes effect at a frame boundary, which prevents tearing.

Parameters:
- SCAN_DIV, 1000, clock cycles per digit slot. Must be ≥ 2.
- GAP_CYC, 50, cycles at the start of each slot with all anodes off. Must satisfy 1 ≤ GAP_CYC < SCAN_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- load  in  1  single-cycle strobe; captures value and dp_in into the pending buffer
- value  in  32  hex value; nibble i is shown on digit i (digit 7 is leftmost)
- dp_in  in  8  decimal point request per digit, 1 = lit
- blank_lz  in  1  1 = blank leading zero digits (sampled live, not buffered)
- an  out  8  digit anodes, active-low
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g
- dp  out  1  decimal point, active-low
- frame_start  out  1  one-cycle pulse when the digit index wraps 7→0

Behaviour:
- Reset (async, rst=1):
  - cnt=0, idx=0; pending, pending_valid and active registers cleared.
  - an=8'hFF, seg=7'h7F, dp=1, frame_start=0.
  - Outputs stay in this state while rst is held.
- Slot counter:
  - cnt runs 0..SCAN_DIV-1.
  - At cnt==SCAN_DIV-1: cnt←0 and idx←(idx+1) mod 8.
  - One frame = 8*SCAN_DIV cycles.
- Slot phase:
  - GAP when cnt < GAP_CYC; ON otherwise.
- Outputs are registered and computed from the current cnt/idx/active, so they are visible one clock later.
  - GAP phase: an=8'hFF, seg=7'h7F, dp=1.
  - ON phase, digit idx not blanked: an has only bit idx low, seg=hex code of active_val[4*idx+3:4*idx], dp=~active_dp[idx].
  - ON phase, digit idx blanked: an bit idx still driven low, seg=7'h7F, dp=~active_dp[idx] (decimal point shows even on a blanked digit).
- Hex code table, {g..a} active-low, digits 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- Leading-zero blanking (blank_lz=1):
  - Digit i is blanked iff every nibble from i up to 7 is zero.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- Buffering:
  - load=1 → pending←{value,dp_in}, pending_valid←1.
  - On the cycle idx wraps 7→0: if pending_valid, active←pending and pending_valid←0. frame_start pulses on that same cycle.
  - load coincident with the wrap: active takes the OLD pending contents, pending takes the new value, pending_valid stays 1.
  - Multiple loads within one frame: the last one wins.
  - A load with pending_valid=0 at the wrap edge is not transferred until the next frame.
- Reset mid-frame:
  - Outputs return to reset values immediately.
  - The first frame after reset starts with idx=0 in GAP phase.
  - Pending data is discarded.

Test Plan (SCAN_DIV=8, GAP_CYC=2):
1. Reset scan: release rst, no load → every slot shows cycles 0–1 with an=FF, then an=FE,FD,…,7F in sequence, each with seg=40 and dp=1. frame_start pulses every 64 cycles.
2. Full hex: load value=32'h89ABCDEF, dp_in=0, blank_lz=0 → from the next frame, digits 0..7 show seg=0E,06,21,46,03,08,10,00, each for 6 cycles per slot.
3. Leading-zero blanking: load 32'h000000A0, blank_lz=1 → digit0 seg=40, digit1 seg=08, digits 2–7 seg=7F with their an bits still pulsed. Then load 0 → only digit0 shows seg=40.
4. Tearing guard:
   - load 32'h11111111 mid-frame → the display is unchanged until the next wrap.
   - load 32'h22222222 on the exact wrap cycle → the following frame shows 1s (seg=79) and the frame after that shows 2s (seg=24).
5. Decimal point: dp_in=8'h05 with value 0 and blank_lz=1 → dp=0 during the ON phase of digits 0 and 2 only, including blanked digit 2 (seg=7F).
6. Async reset mid-slot: assert rst during the ON phase of digit 3 → an=FF, seg=7F, dp=1 without waiting for clk. After release the scan restarts at digit 0 with active=0.
